// File: rtl/match_collect_l4.sv
// match_collect_l4: aligns the enable/byte_pos/pkt_start of each byte slot with
// the compare results that arrive LAT cycles later, builds up to two match
// records per slot (case and nocase) and queues them in a 2-write/1-read
// first-word-fall-through FIFO, counting records accepted and dropped.
//
// Ports:
//   clk, rst                        clock, synchronous active-high reset
//   enable, byte_pos, pkt_start     byte-slot marker, position and packet start
//   compare_out, suffix             case-sensitive hit flags and suffix code
//   compare_out_nocase,
//   suffix_nocase                   case-insensitive hit flags and suffix code
//   m_valid, m_ready, m_data        record stream {nocase, hit, suffix, pos}
//   drop_cnt                        records lost to a full FIFO (saturating)
//   match_cnt                       records accepted since last packet start
module match_collect_l4 #(
  parameter int unsigned LAT   = 4,
  parameter int unsigned DEPTH = 16,
  parameter int unsigned POS_W = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               enable,
  input  logic [POS_W-1:0]   byte_pos,
  input  logic               pkt_start,
  input  logic [1:0]         compare_out,
  input  logic [1:0]         compare_out_nocase,
  input  logic [1:0]         suffix,
  input  logic [1:0]         suffix_nocase,
  output logic               m_valid,
  input  logic               m_ready,
  output logic [POS_W+4:0]   m_data,
  output logic [15:0]        drop_cnt,
  output logic [15:0]        match_cnt
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam int unsigned FW = CW + 1;
  localparam int unsigned DW = POS_W + 5;

  // Slot delay line
  logic [LAT-1:0]   en_q, en_d;
  logic [LAT-1:0]   pkt_q, pkt_d;
  logic [POS_W-1:0] pos_q [LAT];
  logic [POS_W-1:0] pos_d [LAT];

  // FIFO state and counters
  logic [DW-1:0]    mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [15:0]      drop_q, drop_d;
  logic [15:0]      match_q, match_d;

  logic             slot_en, slot_pkt;
  logic [POS_W-1:0] slot_pos;
  logic [DW-1:0]    rec_c, rec_n, wr0_data;
  logic             hit_c, hit_n, acc_c, acc_n, pop, wr0_en, wr1_en;
  logic [AW-1:0]    wr_ptr_nx;
  logic [FW-1:0]    free_slots;
  logic [1:0]       n_hit, n_acc, n_drop;
  logic [16:0]      drop_sum, match_sum;

  assign slot_en  = en_q[LAT-1];
  assign slot_pkt = pkt_q[LAT-1];
  assign slot_pos = pos_q[LAT-1];

  assign m_valid  = (cnt_q != '0);
  assign m_data   = mem_q[rd_ptr_q];
  assign drop_cnt = drop_q;
  assign match_cnt = match_q;

  // Delay line shifts every cycle, independent of enable
  always_comb begin
    en_d[0]  = enable;
    pkt_d[0] = pkt_start;
    pos_d[0] = byte_pos;
    for (int i = 1; i < LAT; i++) begin
      en_d[i]  = en_q[i-1];
      pkt_d[i] = pkt_q[i-1];
      pos_d[i] = pos_q[i-1];
    end
  end

  // Record build, slot allocation (case record wins a single free slot), counters
  always_comb begin
    rec_c = {1'b0, compare_out, suffix, slot_pos};
    rec_n = {1'b1, compare_out_nocase, suffix_nocase, slot_pos};
    hit_c = slot_en & (|compare_out);
    hit_n = slot_en & (|compare_out_nocase);
    pop   = m_valid & m_ready;

    // A same-cycle pop frees a slot for this cycle's writes
    free_slots = FW'(DEPTH) - FW'(cnt_q) + FW'(pop);

    acc_c = hit_c && (free_slots >= FW'(1));
    acc_n = hit_n && (free_slots >= (hit_c ? FW'(2) : FW'(1)));

    n_hit  = 2'(hit_c) + 2'(hit_n);
    n_acc  = 2'(acc_c) + 2'(acc_n);
    n_drop = n_hit - n_acc;

    wr0_en    = acc_c | acc_n;
    wr1_en    = acc_c & acc_n;
    wr0_data  = acc_c ? rec_c : rec_n;
    wr_ptr_nx = wr_ptr_q + AW'(1);

    wr_ptr_d = wr_ptr_q + AW'(n_acc);
    rd_ptr_d = rd_ptr_q + AW'(pop);
    cnt_d    = cnt_q + CW'(n_acc) - CW'(pop);

    drop_sum = {1'b0, drop_q} + 17'(n_drop);
    drop_d   = drop_sum[16] ? 16'hFFFF : drop_sum[15:0];

    match_sum = {1'b0, match_q} + 17'(n_acc);
    if (slot_en && slot_pkt) match_d = 16'(n_acc);
    else                     match_d = match_sum[16] ? 16'hFFFF : match_sum[15:0];
  end

  // Control state
  always_ff @(posedge clk) begin
    if (rst) begin
      en_q     <= '0;
      pkt_q    <= '0;
      for (int i = 0; i < LAT; i++) pos_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      drop_q   <= '0;
      match_q  <= '0;
    end else begin
      en_q     <= en_d;
      pkt_q    <= pkt_d;
      for (int i = 0; i < LAT; i++) pos_q[i] <= pos_d[i];
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
      drop_q   <= drop_d;
      match_q  <= match_d;
    end
  end

  // FIFO storage, not reset
  always_ff @(posedge clk) begin
    if (!rst && wr0_en) mem_q[wr_ptr_q]  <= wr0_data;
    if (!rst && wr1_en) mem_q[wr_ptr_nx] <= rec_n;
  end

endmodule

// File: tb/tb_match_collect_l4.sv
// Directed bench for match_collect_l4 (LAT=4, DEPTH=16, POS_W=16).
module tb_match_collect_l4;

  localparam int unsigned LAT   = 4;
  localparam int unsigned DEPTH = 16;
  localparam int unsigned POS_W = 16;

  logic              clk = 1'b0;
  logic              rst;
  logic              enable;
  logic [POS_W-1:0]  byte_pos;
  logic              pkt_start;
  logic [1:0]        compare_out, compare_out_nocase, suffix, suffix_nocase;
  logic              m_valid, m_ready;
  logic [POS_W+4:0]  m_data;
  logic [15:0]       drop_cnt, match_cnt;

  int n_cmp = 0;
  int n_err = 0;

  match_collect_l4 #(.LAT(LAT), .DEPTH(DEPTH), .POS_W(POS_W)) dut (
    .clk(clk), .rst(rst), .enable(enable), .byte_pos(byte_pos),
    .pkt_start(pkt_start), .compare_out(compare_out),
    .compare_out_nocase(compare_out_nocase), .suffix(suffix),
    .suffix_nocase(suffix_nocase), .m_valid(m_valid), .m_ready(m_ready),
    .m_data(m_data), .drop_cnt(drop_cnt), .match_cnt(match_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Advance one cycle; inputs and samples happen 1 time unit after the edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [63:0] rec(input logic nc, input logic [1:0] hit,
                                      input logic [1:0] sfx, input logic [15:0] pos);
    return 64'({nc, hit, sfx, pos});
  endfunction

  // One slot with compare results LAT cycles later; returns in the cycle
  // where the first record of the slot is visible at the head
  task automatic do_hit(input logic [15:0] pos, input logic pkt,
                        input logic [1:0] c, input logic [1:0] s,
                        input logic [1:0] cn, input logic [1:0] sn);
    enable = 1'b1; byte_pos = pos; pkt_start = pkt;
    step();
    enable = 1'b0; pkt_start = 1'b0; byte_pos = '0;
    repeat (LAT-1) step();
    compare_out = c; suffix = s; compare_out_nocase = cn; suffix_nocase = sn;
    step();
    compare_out = '0; suffix = '0; compare_out_nocase = '0; suffix_nocase = '0;
  endtask

  logic [63:0] first_rec, last_rec;
  int          n_drain;

  initial begin
    rst = 1'b1; enable = 1'b0; byte_pos = '0; pkt_start = 1'b0;
    compare_out = '0; compare_out_nocase = '0; suffix = '0; suffix_nocase = '0;
    m_ready = 1'b0;
    repeat (3) step();

    chk("rst_valid", 64'(m_valid), 64'd0);
    chk("rst_drop",  64'(drop_cnt), 64'd0);
    chk("rst_match", 64'(match_cnt), 64'd0);
    rst = 1'b0;
    step();

    // Single hit with packet start
    m_ready = 1'b1;
    do_hit(16'h0010, 1'b1, 2'b01, 2'b10, 2'b00, 2'b00);
    chk("single_valid", 64'(m_valid), 64'd1);
    chk("single_data",  64'(m_data), rec(1'b0, 2'b01, 2'b10, 16'h0010));
    chk("single_match", 64'(match_cnt), 64'd1);
    step();
    chk("single_popped", 64'(m_valid), 64'd0);

    // Dual hit: case record first, nocase next cycle
    do_hit(16'h0020, 1'b0, 2'b11, 2'b01, 2'b10, 2'b11);
    chk("dual_data0", 64'(m_data), rec(1'b0, 2'b11, 2'b01, 16'h0020));
    chk("dual_match", 64'(match_cnt), 64'd3);
    step();
    chk("dual_valid1", 64'(m_valid), 64'd1);
    chk("dual_data1",  64'(m_data), rec(1'b1, 2'b10, 2'b11, 16'h0020));
    step();
    chk("dual_empty", 64'(m_valid), 64'd0);

    // Gating: compare hits with no valid slot
    compare_out = 2'b11; compare_out_nocase = 2'b11;
    repeat (6) step();
    compare_out = '0; compare_out_nocase = '0;
    step();
    chk("gate_valid", 64'(m_valid), 64'd0);
    chk("gate_match", 64'(match_cnt), 64'd3);

    // Overflow: 9 dual-hit slots into an empty FIFO with no reads
    m_ready = 1'b0;
    first_rec = rec(1'b0, 2'b11, 2'b01, 16'h0100);
    for (int k = 0; k < 13; k++) begin
      enable   = (k < 9);
      byte_pos = 16'h0100 + 16'(k);
      compare_out        = (k >= 4) ? 2'b11 : 2'b00;
      suffix             = (k >= 4) ? 2'b01 : 2'b00;
      compare_out_nocase = (k >= 4) ? 2'b10 : 2'b00;
      suffix_nocase      = (k >= 4) ? 2'b10 : 2'b00;
      step();
      if (k == 4) chk("ovf_first", 64'(m_data), first_rec);
    end
    enable = 1'b0; byte_pos = '0;
    compare_out = '0; suffix = '0; compare_out_nocase = '0; suffix_nocase = '0;
    chk("ovf_drop",  64'(drop_cnt), 64'd2);
    chk("ovf_valid", 64'(m_valid), 64'd1);
    chk("ovf_hold",  64'(m_data), first_rec);
    chk("ovf_match", 64'(match_cnt), 64'd19);

    // Full FIFO, concurrent pop, dual hit
    enable = 1'b1; byte_pos = 16'h0200;
    step();
    enable = 1'b0; byte_pos = '0;
    repeat (LAT-1) step();
    m_ready = 1'b1;
    compare_out = 2'b11; suffix = 2'b01; compare_out_nocase = 2'b10; suffix_nocase = 2'b10;
    step();
    m_ready = 1'b0;
    compare_out = '0; suffix = '0; compare_out_nocase = '0; suffix_nocase = '0;
    chk("full_drop",  64'(drop_cnt), 64'd3);
    chk("full_head",  64'(m_data), rec(1'b1, 2'b10, 2'b10, 16'h0100));
    chk("full_match", 64'(match_cnt), 64'd20);

    // Drain: occupancy must still be 16 with the new case record last
    m_ready = 1'b1;
    n_drain = 0;
    last_rec = '0;
    for (int t = 0; t < 40; t++) begin
      if (!m_valid) break;
      last_rec = 64'(m_data);
      n_drain++;
      step();
    end
    chk("drain_count", 64'(n_drain), 64'd16);
    chk("drain_last",  last_rec, rec(1'b0, 2'b11, 2'b01, 16'h0200));

    // Reset with 5 records queued
    m_ready = 1'b0;
    for (int k = 0; k < 7; k++) begin
      enable   = (k < 3);
      byte_pos = 16'h0300 + 16'(k);
      compare_out        = (k >= 4) ? 2'b01 : 2'b00;
      compare_out_nocase = (k >= 4 && k < 6) ? 2'b10 : 2'b00;
      step();
    end
    enable = 1'b0; byte_pos = '0; compare_out = '0; compare_out_nocase = '0;
    chk("pre_rst_valid", 64'(m_valid), 64'd1);
    chk("pre_rst_match", 64'(match_cnt), 64'd25);
    rst = 1'b1;
    step();
    chk("mid_rst_valid", 64'(m_valid), 64'd0);
    chk("mid_rst_drop",  64'(drop_cnt), 64'd0);
    chk("mid_rst_match", 64'(match_cnt), 64'd0);
    rst = 1'b0;

    m_ready = 1'b1;
    do_hit(16'h0ABC, 1'b0, 2'b01, 2'b11, 2'b00, 2'b00);
    chk("post_rst_valid", 64'(m_valid), 64'd1);
    chk("post_rst_data",  64'(m_data), rec(1'b0, 2'b01, 2'b11, 16'h0ABC));
    chk("post_rst_match", 64'(match_cnt), 64'd1);
    step();
    chk("post_rst_empty", 64'(m_valid), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
